// File: rtl/lock_entry_sequencer.sv
// lock_entry_sequencer: assembles button symbols into a combination, checks it
// against a reprogrammable stored code, and runs the unlock, inactivity-timeout
// and failed-attempt lockout timing with registered status outputs.
module lock_entry_sequencer #(
    parameter int                    CODE_LEN       = 4,
    parameter logic [2*CODE_LEN-1:0] DEFAULT_CODE   = 8'hE4,
    parameter int                    MAX_FAIL       = 3,
    parameter int                    UNLOCK_CYCLES  = 50_000_000,
    parameter int                    LOCKOUT_CYCLES = 250_000_000,
    parameter int                    TIMEOUT_CYCLES = 500_000_000
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [3:0]          button,
    input  logic                prog,
    output logic                unlocked,
    output logic                alarm,
    output logic [CODE_LEN-1:0] progress,
    output logic [2:0]          fail_count,
    output logic [2:0]          state
);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_ENTRY   = 3'd1;
    localparam logic [2:0] S_CHECK   = 3'd2;
    localparam logic [2:0] S_OPEN    = 3'd3;
    localparam logic [2:0] S_PROG    = 3'd4;
    localparam logic [2:0] S_LOCKOUT = 3'd5;

    localparam int MAX_A   = (UNLOCK_CYCLES > LOCKOUT_CYCLES) ? UNLOCK_CYCLES : LOCKOUT_CYCLES;
    localparam int MAX_CYC = (MAX_A > TIMEOUT_CYCLES) ? MAX_A : TIMEOUT_CYCLES;
    localparam int TMR_W   = $clog2(MAX_CYC + 1);
    localparam int IDX_W   = (CODE_LEN > 1) ? $clog2(CODE_LEN) : 1;

    // Timers count down to zero, so a duration of N cycles loads N-1.
    localparam logic [TMR_W-1:0] UNLOCK_LOAD  = TMR_W'(UNLOCK_CYCLES - 1);
    localparam logic [TMR_W-1:0] LOCKOUT_LOAD = TMR_W'(LOCKOUT_CYCLES - 1);
    localparam logic [TMR_W-1:0] TIMEOUT_LOAD = TMR_W'(TIMEOUT_CYCLES - 1);
    localparam logic [IDX_W-1:0] LAST_IDX     = IDX_W'(CODE_LEN - 1);
    localparam logic [2:0]       FAIL_MAX     = 3'(MAX_FAIL);

    logic [TMR_W-1:0]      timer, timer_n;
    logic [IDX_W-1:0]      idx, idx_n;
    logic [2*CODE_LEN-1:0] shadow, shadow_n, shadow_ins;
    logic [2*CODE_LEN-1:0] code, code_n;
    logic [CODE_LEN-1:0]   progress_n, progress_set;
    logic [2:0]            state_n, fail_n, fail_inc;
    logic                  pulse_ok, timer_done;
    logic [1:0]            sym;

    // Qualify the pulse, encode its symbol and precompute the shadow/progress updates.
    always_comb begin
        // NOTE: every signal assigned here gets a default first, so no path leaves it unassigned and no latch is inferred.
        pulse_ok     = (button != 4'b0) && ((button & (button - 4'd1)) == 4'b0);
        sym          = {button[3] | button[2], button[3] | button[1]};
        shadow_ins   = shadow;
        shadow_ins[{idx, 1'b0} +: 2] = sym;
        progress_set = progress | (CODE_LEN'(1) << idx);
        fail_inc     = (fail_count >= FAIL_MAX) ? FAIL_MAX : fail_count + 3'd1;
        timer_done   = (timer == '0);
    end

    // Next-state logic for the sequencer, timer, index, shadow and stored code.
    always_comb begin
        state_n    = state;
        timer_n    = timer;
        idx_n      = idx;
        progress_n = progress;
        fail_n     = fail_count;
        shadow_n   = shadow;
        code_n     = code;
        case (state)
            S_IDLE: begin
                if (pulse_ok) begin
                    shadow_n   = shadow_ins;
                    progress_n = progress_set;
                    timer_n    = TIMEOUT_LOAD;
                    if (CODE_LEN == 1) begin
                        state_n = S_CHECK;
                        idx_n   = '0;
                    end else begin
                        state_n = S_ENTRY;
                        idx_n   = IDX_W'(1);
                    end
                end
            end
            S_ENTRY, S_PROG: begin
                // A pulse on the expiry cycle wins over the timeout.
                if (pulse_ok) begin
                    shadow_n   = shadow_ins;
                    progress_n = progress_set;
                    timer_n    = TIMEOUT_LOAD;
                    if (idx == LAST_IDX) begin
                        idx_n = '0;
                        if (state == S_ENTRY) begin
                            state_n = S_CHECK;
                        end else begin
                            code_n     = shadow_ins;
                            progress_n = '0;
                            state_n    = S_IDLE;
                        end
                    end else begin
                        idx_n = idx + IDX_W'(1);
                    end
                end else if (timer_done) begin
                    state_n    = S_IDLE;
                    idx_n      = '0;
                    progress_n = '0;
                end else begin
                    timer_n = timer - TMR_W'(1);
                end
            end
            S_CHECK: begin
                progress_n = '0;
                if (shadow == code) begin
                    fail_n  = 3'd0;
                    state_n = S_OPEN;
                    timer_n = UNLOCK_LOAD;
                end else begin
                    fail_n = fail_inc;
                    if (fail_inc == FAIL_MAX) begin
                        state_n = S_LOCKOUT;
                        timer_n = LOCKOUT_LOAD;
                    end else begin
                        state_n = S_IDLE;
                    end
                end
            end
            S_OPEN: begin
                // prog takes priority over the unlock hold expiring.
                if (prog) begin
                    state_n    = S_PROG;
                    timer_n    = TIMEOUT_LOAD;
                    idx_n      = '0;
                    progress_n = '0;
                end else if (timer_done) begin
                    state_n = S_IDLE;
                end else begin
                    timer_n = timer - TMR_W'(1);
                end
            end
            S_LOCKOUT: begin
                if (timer_done) begin
                    state_n = S_IDLE;
                    fail_n  = 3'd0;
                end else begin
                    timer_n = timer - TMR_W'(1);
                end
            end
            default: begin
                state_n    = S_IDLE;
                idx_n      = '0;
                progress_n = '0;
            end
        endcase
    end

    // State registers; status flags are registered from the next state so they never glitch.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= S_IDLE;
            timer      <= '0;
            idx        <= '0;
            progress   <= '0;
            fail_count <= 3'd0;
            shadow     <= '0;
            // NOTE: the stored code is a plain register, not a RAM, so it can and must return to DEFAULT_CODE on reset.
            code       <= DEFAULT_CODE;
            unlocked   <= 1'b0;
            alarm      <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments make every register update from the same pre-edge values.
            state      <= state_n;
            timer      <= timer_n;
            idx        <= idx_n;
            progress   <= progress_n;
            fail_count <= fail_n;
            shadow     <= shadow_n;
            code       <= code_n;
            unlocked   <= (state_n == S_OPEN);
            alarm      <= (state_n == S_LOCKOUT);
        end
    end

endmodule

// File: tb/tb_lock_entry_sequencer.sv
// tb_lock_entry_sequencer: per-cycle scoreboard against a queue-based reference
// model of the lock behaviour, with directed scenarios followed by random traffic.
module tb_lock_entry_sequencer;

    localparam int         CODE_LEN = 4;
    localparam int         MAX_FAIL = 3;
    localparam int         U        = 8;
    localparam int         L        = 16;
    localparam int         T        = 20;
    localparam logic [7:0] DEF_CODE = 8'hE4;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] button;
    logic       prog;
    logic       unlocked, alarm;
    logic [3:0] progress;
    logic [2:0] fail_count, state;

    lock_entry_sequencer #(
        .CODE_LEN(CODE_LEN), .DEFAULT_CODE(DEF_CODE), .MAX_FAIL(MAX_FAIL),
        .UNLOCK_CYCLES(U), .LOCKOUT_CYCLES(L), .TIMEOUT_CYCLES(T)
    ) dut (
        .clk(clk), .rst(rst), .button(button), .prog(prog),
        .unlocked(unlocked), .alarm(alarm), .progress(progress),
        .fail_count(fail_count), .state(state)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [2:0] st;
        logic       unl;
        logic       alm;
        logic [3:0] prg;
        logic [2:0] fc;
    } exp_t;

    exp_t exp_q[$];
    int   total = 0;
    int   bad   = 0;

    // Reference model: the entry in progress is a queue of symbols, and each
    // timed phase is a count of cycles still to run.
    int code_sym[CODE_LEN];
    int entered[$];
    bit in_prog, in_check;
    int open_left, lock_left, idle_left, fails;

    task automatic check(input string name, input logic [7:0] got, input logic [7:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got %0h, want %0h at t=%0t", name, got, want, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < CODE_LEN; i++) code_sym[i] = (DEF_CODE >> (2 * i)) & 8'h3;
        entered.delete();
        in_prog = 0; in_check = 0;
        open_left = 0; lock_left = 0; idle_left = 0; fails = 0;
    endtask

    function automatic exp_t model_outputs();
        exp_t e;
        e.unl = (open_left > 0);
        e.alm = (lock_left > 0);
        e.fc  = 3'(fails);
        e.prg = 4'((1 << entered.size()) - 1);
        if (lock_left > 0)          e.st = 3'd5;
        else if (open_left > 0)     e.st = 3'd3;
        else if (in_check)          e.st = 3'd2;
        else if (in_prog)           e.st = 3'd4;
        else if (entered.size() > 0) e.st = 3'd1;
        else                        e.st = 3'd0;
        return e;
    endfunction

    // Advance the model by one clock edge with the given inputs.
    task automatic model_step(input logic [3:0] b, input logic p);
        int nbits, s;
        bit match;
        nbits = 0; s = 0;
        for (int i = 0; i < 4; i++) if (b[i]) begin nbits++; s = i; end
        if (lock_left > 0) begin
            lock_left--;
            if (lock_left == 0) fails = 0;
        end else if (open_left > 0) begin
            if (p) begin
                open_left = 0; in_prog = 1; idle_left = T;
            end else begin
                open_left--;
            end
        end else if (in_check) begin
            match = 1;
            for (int i = 0; i < CODE_LEN; i++) if (entered[i] != code_sym[i]) match = 0;
            in_check = 0;
            entered.delete();
            if (match) begin
                fails = 0; open_left = U;
            end else begin
                fails++;
                if (fails >= MAX_FAIL) begin fails = MAX_FAIL; lock_left = L; end
            end
        end else if (nbits == 1) begin
            entered.push_back(s);
            idle_left = T;
            if (entered.size() == CODE_LEN) begin
                if (in_prog) begin
                    for (int i = 0; i < CODE_LEN; i++) code_sym[i] = entered[i];
                    entered.delete();
                    in_prog = 0;
                end else begin
                    in_check = 1;
                end
            end
        end else if (in_prog || entered.size() > 0) begin
            idle_left--;
            if (idle_left == 0) begin entered.delete(); in_prog = 0; end
        end
        exp_q.push_back(model_outputs());
    endtask

    // Monitor: compares every DUT output against the expectation for that edge.
    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("state",      {5'b0, state},      {5'b0, e.st});
                check("unlocked",   {7'b0, unlocked},   {7'b0, e.unl});
                check("alarm",      {7'b0, alarm},      {7'b0, e.alm});
                check("progress",   {4'b0, progress},   {4'b0, e.prg});
                check("fail_count", {5'b0, fail_count}, {5'b0, e.fc});
            end
        end
    end

    task automatic cycle(input logic [3:0] b, input logic p);
        @(negedge clk);
        button = b;
        prog   = p;
        model_step(b, p);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(4'b0, 1'b0);
    endtask

    task automatic press(input int s, input int gap);
        cycle(4'(1 << s), 1'b0);
        idle(gap);
    endtask

    task automatic enter(input int s0, input int s1, input int s2, input int s3, input int gap);
        press(s0, gap); press(s1, gap); press(s2, gap); press(s3, gap);
    endtask

    // Assert reset between edges and confirm the outputs clear without a clock edge.
    task automatic async_reset(input string tag);
        @(posedge clk);
        #3;
        button = 4'b0;
        prog   = 1'b0;
        rst    = 1'b1;
        #1;
        check({tag, "_state"},    {5'b0, state},      8'd0);
        check({tag, "_unlocked"}, {7'b0, unlocked},   8'd0);
        check({tag, "_alarm"},    {7'b0, alarm},      8'd0);
        check({tag, "_progress"}, {4'b0, progress},   8'd0);
        check({tag, "_fail"},     {5'b0, fail_count}, 8'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        model_reset();
    endtask

    // One random transaction: a correct or random entry with gaps and junk.
    task automatic rand_entry(input bit use_code);
        int gap;
        logic [3:0] junk;
        gap = $urandom_range(0, 3);
        for (int k = 0; k < CODE_LEN; k++) begin
            press(use_code ? code_sym[k] : $urandom_range(0, 3), 0);
            for (int g = 0; g < gap; g++) begin
                junk = ($urandom_range(0, 5) == 0) ? 4'(3 << $urandom_range(0, 2)) : 4'b0;
                cycle(junk, 1'b0);
            end
        end
    endtask

    initial begin : watchdog
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin : stimulus
        int r;
        rst    = 1'b1;
        button = 4'b0;
        prog   = 1'b0;
        model_reset();
        #1;
        check("reset_state",    {5'b0, state},      8'd0);
        check("reset_unlocked", {7'b0, unlocked},   8'd0);
        check("reset_alarm",    {7'b0, alarm},      8'd0);
        check("reset_progress", {4'b0, progress},   8'd0);
        check("reset_fail",     {5'b0, fail_count}, 8'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        // Correct default code, pulses spaced 3 cycles.
        enter(0, 1, 2, 3, 2);
        idle(U + 4);

        // Wrong code three times, then buttons hammered during lockout.
        for (int n = 0; n < 3; n++) begin
            enter(0, 0, 0, 0, 1);
            idle(2);
        end
        for (int k = 0; k < 10; k++) cycle(4'(1 << (k % 4)), 1'b0);
        idle(L);

        // Abandoned entry, then a correct code.
        press(0, 2); press(1, 2);
        idle(T + 2);
        enter(0, 1, 2, 3, 1);
        idle(U + 3);

        // Multi-bit pulse mid-entry must not reload the timeout.
        press(0, 0);
        idle(T - 3);
        cycle(4'b0011, 1'b0);
        idle(4);

        // Valid pulse on the exact expiry edge is accepted.
        press(0, T - 1);
        press(1, T - 1);
        press(2, 0);
        press(3, 1);
        idle(U + 3);

        // prog on the final OPEN cycle, then reprogram to 3,3,2,1.
        enter(0, 1, 2, 3, 0);
        idle(U);
        cycle(4'b0, 1'b1);
        enter(3, 3, 2, 1, 1);
        idle(3);
        enter(0, 1, 2, 3, 1);
        idle(3);
        enter(3, 3, 2, 1, 1);
        idle(U + 3);

        // Abandoned programming session leaves the code alone.
        enter(3, 3, 2, 1, 0);
        idle(2);
        cycle(4'b0, 1'b1);
        press(0, 2);
        idle(T + 2);
        enter(3, 3, 2, 1, 1);
        idle(U + 3);

        // Reset in the middle of programming; default code must work again.
        enter(3, 3, 2, 1, 1);
        idle(3);
        cycle(4'b0, 1'b1);
        press(2, 1);
        async_reset("rst_prog");
        enter(0, 1, 2, 3, 1);
        idle(U + 3);

        // Reset in the middle of lockout.
        for (int n = 0; n < 3; n++) begin
            enter(1, 1, 1, 1, 0);
            idle(2);
        end
        idle(5);
        async_reset("rst_lock");
        enter(0, 1, 2, 3, 0);
        idle(U + 3);

        // Random traffic.
        for (int it = 0; it < 250; it++) begin
            r = $urandom_range(0, 9);
            if (r <= 3) begin
                rand_entry(1'b1);
            end else if (r <= 6) begin
                rand_entry(1'b0);
            end else if (r == 7) begin
                for (int k = 0; k < 6; k++) cycle(4'($urandom_range(0, 15)), 1'b0);
            end else begin
                for (int k = 0; k < $urandom_range(0, 24); k++)
                    cycle(4'b0, ($urandom_range(0, 7) == 0));
            end
        end

        idle(2);
        repeat (3) @(negedge clk);
        check("queue_drain", 8'(exp_q.size()), 8'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
